// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input and back-to-back framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 35,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
      StParity = 3'd3,
`endif
      StStop   = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [3:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic baud_wrap;
   logic last_stop;
   logic accept;

   assign baud_wrap = (baud_q == BaudLast);
   assign last_stop = (state_q == StStop) && baud_wrap && (bit_q == StopLast);
   assign in_ready  = (state_q == StIdle) || last_stop;
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         StIdle: begin
            baud_d = '0;
            bit_d  = '0;
         end
         StStart: begin
            if (baud_wrap) begin
               state_d = StData;
               baud_d  = '0;
               bit_d   = '0;
            end
         end
         StData: begin
            if (baud_wrap) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 4'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (baud_wrap) begin
               state_d = StStop;
               baud_d  = '0;
               bit_d   = '0;
            end
         end
`endif
         StStop: begin
            if (baud_wrap) begin
               baud_d = '0;
               if (bit_q == StopLast) begin
                  state_d = StIdle;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase

      // Accept overrides the IDLE/STOP decisions above, giving zero-gap back-to-back frames.
      if (accept) begin
         state_d  = StStart;
         baud_d   = '0;
         bit_d    = '0;
         shift_d  = in_data;
`ifdef UART_TX_PARITY_EN
         parity_d = ^in_data;
`endif
      end

      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase

      busy_d = (state_d != StIdle);
      // Look ahead so the registered pulse lines up with the last stop cycle itself.
      done_d = (state_d == StStop) && (baud_d == BaudLast) && (bit_d == StopLast);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: one instance with defaults, one with two stop bits.
module tb_uart_tx;

   localparam int CPB = 35;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int LEN1 = (9 + 1 + PAR) * CPB;
   localparam int LEN2 = (9 + 2 + PAR) * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       v1, r1, tx1, b1, fd1;
   logic [7:0] d1;
   logic       v2, r2, tx2, b2, fd2;
   logic [7:0] d2;

   int vectors = 0;
   int miscompares = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
      .tx(tx1), .busy(b1), .frame_done(fd1)
   );

   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(d2),
      .tx(tx2), .busy(b2), .frame_done(fd2)
   );

   task automatic push_frame(input logic [7:0] b, input int stops);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      if (PAR == 1) exp_q.push_back(^b);
      for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      v1 = 1'b0; d1 = 8'h00;
      v2 = 1'b0; d2 = 8'h00;
      #1;
      for (int c = 0; c < 3; c++) begin
         vectors++;
         if (tx1 !== 1'b1 || b1 !== 1'b0 || fd1 !== 1'b0 || tx2 !== 1'b1 || b2 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got tx=%b busy=%b done=%b tx2=%b busy2=%b want 1 0 0 1 0",
                     tx1, b1, fd1, tx2, b2);
         end
         @(negedge clk);
      end
      rst = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         vectors++;
         if (tx1 !== 1'b1 || r1 !== 1'b1 || b1 !== 1'b0 || fd1 !== 1'b0 || fd2 !== 1'b0) begin
            miscompares++;
            $display("FAIL idle c=%0d got tx=%b rdy=%b busy=%b done=%b done2=%b want 1 1 0 0 0",
                     c, tx1, r1, b1, fd1, fd2);
         end
      end
   endtask

   // Sends one byte on dut1 and checks every cycle of the frame; disturb wiggles inputs mid-frame.
   task automatic test_frame(input logic [7:0] b, input bit disturb);
      logic cur;
      @(negedge clk);
      vectors++;
      if (r1 !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_before_send got %b want 1", r1);
      end
      v1 = 1'b1;
      d1 = b;
      push_frame(b, 1);
      @(negedge clk);
      v1 = 1'b0;
      cur = 1'b1;
      for (int k = 0; k < LEN1; k++) begin
         if (k % CPB == 0 && exp_q.size() > 0) cur = exp_q.pop_front();
         vectors++;
         if (tx1 !== cur) begin
            miscompares++;
            $display("FAIL tx byte=%h k=%0d got %b want %b", b, k, tx1, cur);
         end
         vectors++;
         if (fd1 !== (k == LEN1 - 1)) begin
            miscompares++;
            $display("FAIL frame_done k=%0d got %b want %b", k, fd1, (k == LEN1 - 1));
         end
         vectors++;
         if (b1 !== 1'b1 || r1 !== (k == LEN1 - 1)) begin
            miscompares++;
            $display("FAIL busy_ready k=%0d got busy=%b rdy=%b want 1 %b", k, b1, r1,
                     (k == LEN1 - 1));
         end
         if (disturb && k == 100) begin
            d1 = 8'h3C;
            v1 = 1'b1;
         end
         if (disturb && k == 300) v1 = 1'b0;
         @(negedge clk);
      end
      vectors++;
      if (tx1 !== 1'b1 || b1 !== 1'b0 || fd1 !== 1'b0 || r1 !== 1'b1) begin
         miscompares++;
         $display("FAIL after_frame got tx=%b busy=%b done=%b rdy=%b want 1 0 0 1",
                  tx1, b1, fd1, r1);
      end
   endtask

   task automatic test_single_frame();
      test_frame(8'hA5, 1'b0);
      test_frame(8'h00, 1'b0);
   endtask

   task automatic test_ignore_midframe();
      test_frame(8'hA5, 1'b1);
   endtask

   task automatic test_reset_midframe();
      logic cur;
      @(negedge clk);
      v1 = 1'b1;
      d1 = 8'h55;
      push_frame(8'h55, 1);
      @(negedge clk);
      v1 = 1'b0;
      cur = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (k % CPB == 0 && exp_q.size() > 0) cur = exp_q.pop_front();
         vectors++;
         if (tx1 !== cur) begin
            miscompares++;
            $display("FAIL tx_pre_reset k=%0d got %b want %b", k, tx1, cur);
         end
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      exp_q.delete();
      vectors++;
      if (tx1 !== 1'b1 || b1 !== 1'b0 || fd1 !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset got tx=%b busy=%b done=%b want 1 0 0", tx1, b1, fd1);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if (fd1 !== 1'b0 || tx1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hold c=%0d got done=%b tx=%b want 0 1", c, fd1, tx1);
         end
      end
      rst = 1'b0;
      test_frame(8'h96, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic cur;
      logic want;
      @(negedge clk);
      vectors++;
      if (r2 !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_ready_start got %b want 1", r2);
      end
      v2 = 1'b1;
      d2 = 8'h00;
      push_frame(8'h00, 2);
      push_frame(8'hFF, 2);
      @(negedge clk);
      d2 = 8'hFF;
      cur = 1'b1;
      for (int k = 0; k < 2 * LEN2; k++) begin
         if (k % CPB == 0 && exp_q.size() > 0) cur = exp_q.pop_front();
         want = (k == LEN2 - 1) || (k == 2 * LEN2 - 1);
         vectors++;
         if (tx2 !== cur) begin
            miscompares++;
            $display("FAIL b2b_tx k=%0d got %b want %b", k, tx2, cur);
         end
         vectors++;
         if (fd2 !== want || r2 !== want || b2 !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ctrl k=%0d got done=%b rdy=%b busy=%b want %b %b 1",
                     k, fd2, r2, b2, want, want);
         end
         if (k == LEN2) v2 = 1'b0;
         @(negedge clk);
      end
      vectors++;
      if (tx2 !== 1'b1 || b2 !== 1'b0 || fd2 !== 1'b0 || r2 !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_after got tx=%b busy=%b done=%b rdy=%b want 1 0 0 1",
                  tx2, b2, fd2, r2);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      test_frame(8'hA5, 1'b0);
      test_frame(8'h07, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_ignore_midframe();
      test_back_to_back();
      test_reset_midframe();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serialises bytes from the main logic onto the `tx` line as 8N1 frames (start bit, 8 data bits LSB first, STOP_BITS stop bits).
- Bit timing matches the board UART receiver: same CLKS_PER_BIT, so both ends of the link agree on baud.
- Byte-wide valid/ready input; sits between main logic and the FPGA `tx` pin, alongside the receiver.

Parameters:
CLKS_PER_BIT, 35, clock cycles per serial bit; must be >= 2
STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2

Ports:
clk  input  1  system clock; one clock; all logic on posedge clk
rst  input  1  reset is asynchronous and active-high
in_valid  input  1  in_data holds a byte to send
in_ready  output  1  block accepts a byte this cycle when in_valid is also high
in_data  input  8  byte to transmit; sampled only on accept
tx  output  1  serial line, idle high, driven straight from a flop
busy  output  1  high while a frame is in progress (state != IDLE)
frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset (async, rst=1): state=IDLE, tx=1, busy=0, frame_done=0, all counters cleared. After reset release, in_ready=1.
- Accept: a byte is accepted when in_valid && in_ready at a posedge. in_data is latched into a 8-bit shift register.
- States and transitions:
  - IDLE: tx=1. On accept -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits, each CLKS_PER_BIT cycles, shift register bit 0 first; shift right once per bit -> STOP after bit 7.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles -> IDLE, or -> START directly if a byte is accepted on the final cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Clears on state entry.
  - Bit boundary = wrap.
  - Width $clog2(CLKS_PER_BIT).
- Bit counter: counts data bits 0..7 in DATA and stop bits in STOP. Width 4.
- Latency:
  - tx falls on the cycle after the accept edge, because tx is registered from next-state logic.
  - Each bit is exactly CLKS_PER_BIT cycles.
  - Frame length is (9+STOP_BITS)*CLKS_PER_BIT cycles: 350 with defaults.
- in_ready = (state==IDLE) || (state==STOP && last cycle of last stop bit). This allows back-to-back frames with zero idle cycles between the stop bit and the next start bit.
- frame_done asserts on the last cycle of the final stop bit, including when a back-to-back accept occurs on that same cycle.
- in_data or in_valid changes while busy and not ready: ignored; no effect on the frame in flight.
- Reset mid-frame: tx returns to 1 immediately (async). The partial frame is abandoned and no frame_done pulse is produced.
- Illegal state encodings: recover to IDLE with tx=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx = even parity (XOR of the 8 latched data bits), computed at accept.
  - Frame length becomes (10+STOP_BITS)*CLKS_PER_BIT.
- Undefined: no PARITY state; 8N1 framing exactly as above.

Test Plan:
- Reset release then idle 100 cycles -> tx=1, in_ready=1, busy=0, frame_done never pulses.
- Accept 0xA5 (defaults) -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 35 cycles. tx falls 1 cycle after accept; frame_done pulses at cycle 350 after accept; busy high throughout.
- in_valid held high with 0x00 then 0xFF, STOP_BITS=2 -> second accept occurs on the final stop cycle. The second start bit follows immediately with no idle gap; each frame is 385 cycles; two frame_done pulses 385 cycles apart.
- in_data changed to 0x3C mid-frame while in_ready=0 -> transmitted bits still match the originally accepted 0xA5.
- rst asserted at cycle 100 of a 0x55 frame -> tx=1 same cycle, busy=0, no frame_done. A new byte accepted after release transmits correctly.
- With UART_TX_PARITY_EN, send 0xA5 then 0x07 -> parity bits are 0 and 1. Each frame is 385 cycles.
